// File: rtl/sa.sv
`default_nettype none
// ============================================================================
// sa : output-stationary NxN signed systolic array, C = A*B (accumulates in place)
// Rev 1.0
// ============================================================================
module sa #(
  parameter int WIDTH = 8,
  parameter int ACC   = 32,
  parameter int N     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N*WIDTH-1:0]   a_in,
  input  logic [N*WIDTH-1:0]   b_in,
  output logic [N*N*ACC-1:0]   acc_out
);

  // Flattened ports: a_in/b_in element k at [k*WIDTH +: WIDTH],
  // acc_out element (i,j) at [(i*N+j)*ACC +: ACC].
  logic signed [WIDTH-1:0] a_mesh [N][N];
  logic signed [WIDTH-1:0] b_mesh [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [WIDTH-1:0]   a_d, b_d, a_q, b_q;
      logic signed [2*WIDTH-1:0] prod;
      logic signed [ACC-1:0]     acc_d, acc_q;

      if (j == 0) begin : g_west
        assign a_d = a_in[i*WIDTH +: WIDTH];
      end else begin : g_a_chain
        assign a_d = a_mesh[i][j-1];
      end

      if (i == 0) begin : g_north
        assign b_d = b_in[j*WIDTH +: WIDTH];
      end else begin : g_b_chain
        assign b_d = b_mesh[i-1][j];
      end

      assign prod  = a_d * b_d;
      assign acc_d = acc_q + ACC'(prod);

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (en) begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
        end
      end

      assign a_mesh[i][j] = a_q;
      assign b_mesh[i][j] = b_q;
      assign acc_out[(i*N+j)*ACC +: ACC] = acc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa.sv
`default_nettype none
// ============================================================================
// tb_sa : directed + randomized self-checking bench for sa (2x2/ACC32, 3x3/ACC16)
// Rev 1.0
// ============================================================================
module tb_sa;
  localparam int W = 8, ACC = 32, N = 2, ACC3 = 16, N3 = 3;

  logic clk = 1'b0;
  logic rst, en, en3;
  logic [N*W-1:0]         a_in, b_in;
  logic [N*N*ACC-1:0]     acc_out;
  logic [N3*W-1:0]        a3, b3;
  logic [N3*N3*ACC3-1:0]  acc3;

  int tests = 0, fails = 0;
  int mA [N][N], mB [N][N];
  longint exp_c [N][N];
  int m3A [N3][N3], m3B [N3][N3];
  longint exp3 [N3][N3];

  sa #(.WIDTH(W), .ACC(ACC), .N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .acc_out(acc_out));

  sa #(.WIDTH(W), .ACC(ACC3), .N(N3)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .a_in(a3), .b_in(b3), .acc_out(acc3));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Skewed feeder for the 2x2 array
  function automatic logic [N*W-1:0] feed_a(int t);
    logic [N*W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      int k = t - i;
      if (k >= 0 && k < N) r[i*W +: W] = W'(mA[i][k]);
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] feed_b(int t);
    logic [N*W-1:0] r = '0;
    for (int j = 0; j < N; j++) begin
      int k = t - j;
      if (k >= 0 && k < N) r[j*W +: W] = W'(mB[k][j]);
    end
    return r;
  endfunction

  function automatic logic [N3*W-1:0] feed3_a(int t);
    logic [N3*W-1:0] r = '0;
    for (int i = 0; i < N3; i++) begin
      int k = t - i;
      if (k >= 0 && k < N3) r[i*W +: W] = W'(m3A[i][k]);
    end
    return r;
  endfunction

  function automatic logic [N3*W-1:0] feed3_b(int t);
    logic [N3*W-1:0] r = '0;
    for (int j = 0; j < N3; j++) begin
      int k = t - j;
      if (k >= 0 && k < N3) r[j*W +: W] = W'(m3B[k][j]);
    end
    return r;
  endfunction

  // Reference: plain matrix product added to the running total
  task automatic add_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          exp_c[i][j] += longint'(mA[i][k]) * longint'(mB[k][j]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_c[i][j] = 0;
    for (int i = 0; i < N3; i++)
      for (int j = 0; j < N3; j++) exp3[i][j] = 0;
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        logic [ACC-1:0] e;
        e = exp_c[i][j][ACC-1:0];
        chk($sformatf("%s_c%0d%0d", tag, i, j),
            $signed(acc_out[(i*N+j)*ACC +: ACC]), $signed(e));
      end
  endtask

  task automatic check3(string tag);
    for (int i = 0; i < N3; i++)
      for (int j = 0; j < N3; j++) begin
        logic [ACC3-1:0] e;
        e = exp3[i][j][ACC3-1:0];
        chk($sformatf("%s_c%0d%0d", tag, i, j),
            $signed(acc3[(i*N3+j)*ACC3 +: ACC3]), $signed(e));
      end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'($urandom);
    en3  = 1'($urandom);
    a_in = (N*W)'($urandom);
    b_in = (N*W)'($urandom);
    a3   = (N3*W)'($urandom);
    b3   = (N3*W)'($urandom);
    repeat (3) tick();
    rst = 1'b0; en = 1'b0; en3 = 1'b0;
    a_in = '0; b_in = '0; a3 = '0; b3 = '0;
    clear_model();
  endtask

  // Six skewed enabled cycles, optional feeder-frozen pause, then a 4-cycle drain
  task automatic run_product(int pause_at, int pause_len, string tag);
    logic [N*N*ACC-1:0] snap;
    add_model();
    for (int t = 0; t < 6; t++) begin
      if (t == pause_at) begin
        snap = acc_out;
        en   = 1'b0;
        a_in = feed_a(t);
        b_in = feed_b(t);
        for (int p = 0; p < pause_len; p++) begin
          tick();
          chk($sformatf("%s_hold%0d", tag, p), 64'(acc_out === snap), 64'd1);
        end
      end
      en   = 1'b1;
      a_in = feed_a(t);
      b_in = feed_b(t);
      tick();
      if (t == 3) check_all({tag, "_e4"});
    end
    en = 1'b0; a_in = '0; b_in = '0;
    repeat (4) tick();
    check_all({tag, "_end"});
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; en3 = 1'b0;
    a_in = '0; b_in = '0; a3 = '0; b3 = '0;
    clear_model();

    // Reset with random inputs and enables
    do_reset();
    check_all("reset");
    check3("reset3");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        chk($sformatf("reset_aq%0d%0d", i, j), dut.a_mesh[i][j], 0);
        chk($sformatf("reset_bq%0d%0d", i, j), dut.b_mesh[i][j], 0);
      end

    // Basic 2x2
    mA = '{'{1, 2}, '{3, 4}};
    mB = '{'{5, 6}, '{7, 8}};
    run_product(-1, 0, "basic");

    // Signed extremes
    do_reset();
    mA = '{'{-128, -128}, '{127, -1}};
    mB = '{'{-128, 127}, '{-128, -128}};
    run_product(-1, 0, "ext");

    // Enable gating with frozen feeder
    do_reset();
    mA = '{'{1, 2}, '{3, 4}};
    mB = '{'{5, 6}, '{7, 8}};
    run_product(2, 3, "gate");

    // Accumulate without reset, then reset mid-run
    do_reset();
    run_product(-1, 0, "acc1");
    run_product(-1, 0, "acc2");
    for (int t = 0; t < 2; t++) begin
      en = 1'b1; a_in = feed_a(t); b_in = feed_b(t);
      tick();
    end
    rst = 1'b1; en = 1'b1; a_in = feed_a(2); b_in = feed_b(2);
    tick();
    rst = 1'b0; en = 1'b0; a_in = '0; b_in = '0;
    clear_model();
    check_all("midrst");

    // Randomized products, sometimes accumulating across runs
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) do_reset();
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          mA[i][j] = rnd8();
          mB[i][j] = rnd8();
        end
      run_product(int'($urandom_range(0, 5)), int'($urandom_range(1, 3)),
                  $sformatf("rand%0d", r));
    end

    // 16-bit wrap on a 3x3 array
    do_reset();
    for (int i = 0; i < N3; i++)
      for (int j = 0; j < N3; j++) begin
        m3A[i][j] = (i == 0) ? 127 : rnd8();
        m3B[i][j] = (j == 0) ? 127 : rnd8();
      end
    for (int i = 0; i < N3; i++)
      for (int j = 0; j < N3; j++)
        for (int k = 0; k < N3; k++)
          exp3[i][j] += longint'(m3A[i][k]) * longint'(m3B[k][j]);
    for (int t = 0; t < 3*N3 - 2; t++) begin
      en3 = 1'b1; a3 = feed3_a(t); b3 = feed3_b(t);
      tick();
    end
    en3 = 1'b0; a3 = '0; b3 = '0;
    repeat (3) tick();
    check3("wrap");
    chk("wrap_c00_const", $signed(acc3[ACC3-1:0]), -17149);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
